// File: rtl/line_pkg.sv
// Shared definitions for the line drawing pipeline (line engine, animation,
// framebuffer): drawing FSM state encoding, screen limits, coordinate widths.
// Ports: none (package).
package line_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } line_state_t;

  localparam int X_MAX   = 639;
  localparam int Y_MAX   = 479;
  localparam int X_W_DEF = 10;
  localparam int Y_W_DEF = 9;

  function automatic int cmax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/line_octant_normalize.sv
// Folds an arbitrary line into the first-octant form the stepper walks:
// picks the major axis, orders endpoints along it, derives deltas and minor step.
// Ports: ax0/ay0/ax1/ay1 endpoints in; steep, major start/end, minor start,
//        dx (major delta), dy (|minor delta|), ystep_neg (minor steps down) out.
module line_octant_normalize
  import line_pkg::*;
#(
  parameter int CW = 10
) (
  input  logic [CW-1:0] ax0,
  input  logic [CW-1:0] ay0,
  input  logic [CW-1:0] ax1,
  input  logic [CW-1:0] ay1,
  output logic          steep,
  output logic [CW-1:0] maj_start,
  output logic [CW-1:0] min_start,
  output logic [CW-1:0] maj_end,
  output logic [CW-1:0] dx,
  output logic [CW-1:0] dy,
  output logic          ystep_neg
);

  logic [CW-1:0] adx;
  logic [CW-1:0] ady;
  logic [CW-1:0] maj0;
  logic [CW-1:0] min0;
  logic [CW-1:0] maj1;
  logic [CW-1:0] min1;
  logic [CW-1:0] min_end;
  logic          rev;

  assign adx   = (ax1 >= ax0) ? (ax1 - ax0) : (ax0 - ax1);
  assign ady   = (ay1 >= ay0) ? (ay1 - ay0) : (ay0 - ay1);
  assign steep = (ady > adx);

  // Steep lines are walked along y, so exchange the roles of the axes.
  assign maj0 = steep ? ay0 : ax0;
  assign min0 = steep ? ax0 : ay0;
  assign maj1 = steep ? ay1 : ax1;
  assign min1 = steep ? ax1 : ay1;

  // Always walk the major axis upwards.
  assign rev       = (maj0 > maj1);
  assign maj_start = rev ? maj1 : maj0;
  assign min_start = rev ? min1 : min0;
  assign maj_end   = rev ? maj0 : maj1;
  assign min_end   = rev ? min0 : min1;

  assign dx        = maj_end - maj_start;
  assign dy        = (min_end >= min_start) ? (min_end - min_start) : (min_start - min_end);
  assign ystep_neg = (min_end < min_start);

endmodule

// File: rtl/bresenham_line_engine.sv
// Bresenham line rasteriser: latches one line on start, emits one pixel per
// cycle (first pixel two cycles after start, done one cycle after the last).
// Ports: clk, reset_n, start, x0/y0/x1/y1, color_in in; x, y, pixel_color,
//        pixel_write, busy, done out. start is ignored (not queued) while busy.
module bresenham_line_engine
  import line_pkg::*;
#(
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y1,
  input  logic           color_in,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           pixel_color,
  output logic           pixel_write,
  output logic           busy,
  output logic           done
);

  // Common coordinate width for both axes once they may be swapped;
  // for landscape screens this is X_W, so the error register is X_W+2 bits.
  localparam int CW = cmax(X_W, Y_W);
  localparam int EW = CW + 2;
  localparam logic [CW-1:0] ONE = CW'(1);

  line_state_t state;

  logic [CW-1:0] lx0, ly0, lx1, ly1;
  logic          steep_r;
  logic [CW-1:0] cur_maj;
  logic [CW-1:0] cur_min;
  logic [CW-1:0] maj_end_r;
  logic [CW-1:0] dx_r;
  logic [CW-1:0] dy_r;
  logic          ystep_neg_r;
  logic signed [EW-1:0] err;
  logic          last_r;

  logic          n_steep;
  logic [CW-1:0] n_maj_start;
  logic [CW-1:0] n_min_start;
  logic [CW-1:0] n_maj_end;
  logic [CW-1:0] n_dx;
  logic [CW-1:0] n_dy;
  logic          n_ystep_neg;

  logic signed [EW-1:0] err_sum;
  logic                 step_min;

  line_octant_normalize #(.CW(CW)) u_norm (
    .ax0       (lx0),
    .ay0       (ly0),
    .ax1       (lx1),
    .ay1       (ly1),
    .steep     (n_steep),
    .maj_start (n_maj_start),
    .min_start (n_min_start),
    .maj_end   (n_maj_end),
    .dx        (n_dx),
    .dy        (n_dy),
    .ystep_neg (n_ystep_neg)
  );

  assign err_sum = err + $signed({2'b00, dy_r});
  // A flat line with dx==1 starts with error 0; the dy guard keeps it from
  // stepping off the line when there is no minor movement at all.
  assign step_min = !err_sum[EW-1] && (dy_r != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      lx0         <= '0;
      ly0         <= '0;
      lx1         <= '0;
      ly1         <= '0;
      steep_r     <= 1'b0;
      cur_maj     <= '0;
      cur_min     <= '0;
      maj_end_r   <= '0;
      dx_r        <= '0;
      dy_r        <= '0;
      ystep_neg_r <= 1'b0;
      err         <= '0;
      last_r      <= 1'b0;
      x           <= '0;
      y           <= '0;
      pixel_color <= 1'b0;
      pixel_write <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pixel_write <= 1'b0;
          done        <= 1'b0;
          if (start) begin
            lx0         <= CW'(x0);
            ly0         <= CW'(y0);
            lx1         <= CW'(x1);
            ly1         <= CW'(y1);
            pixel_color <= color_in;
            busy        <= 1'b1;
            state       <= SETUP;
          end
        end
        SETUP: begin
          steep_r     <= n_steep;
          cur_maj     <= n_maj_start;
          cur_min     <= n_min_start;
          maj_end_r   <= n_maj_end;
          dx_r        <= n_dx;
          dy_r        <= n_dy;
          ystep_neg_r <= n_ystep_neg;
          err         <= -$signed({2'b00, n_dx >> 1});
          last_r      <= 1'b0;
          state       <= DRAW;
        end
        DRAW: begin
          if (last_r) begin
            // Last pixel was presented on the previous cycle.
            pixel_write <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            pixel_write <= 1'b1;
            x           <= X_W'(steep_r ? cur_min : cur_maj);
            y           <= Y_W'(steep_r ? cur_maj : cur_min);
            if (cur_maj == maj_end_r) begin
              last_r <= 1'b1;
            end else begin
              cur_maj <= cur_maj + ONE;
              if (step_min) begin
                cur_min <= ystep_neg_r ? (cur_min - ONE) : (cur_min + ONE);
                err     <= err_sum - $signed({2'b00, dx_r});
              end else begin
                err <= err_sum;
              end
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
